branch_redirect_unit: RTL and testbench

// - Consumer of the word-aligned branch offset SignImmD_shift2 produced in decode.
// - Resolves the branch, jump or jump-register target and holds it until the

---
 rtl/branch_redirect_unit.sv | 114 +++++++++++
 tb/tb_branch_redirect_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// ============================================================================
// Module   : branch_redirect_unit
// Brief    : Resolves branch/J/JR targets, holds them across the MIPS delay
//            slot fetch, then redirects the fetch PC over valid/ready.
//            Optional misaligned-target flag: macro BR_ADDR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_unit #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] PC_RESET = 32'hBFC0_0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ValidD,
  input  logic          BranchTakenD,
  input  logic          JumpD,
  input  logic          JumpRegD,
  input  logic [DW-1:0] PCPlus4D,
  input  logic [DW-1:0] SignImmD_shift2,
  input  logic [25:0]   InstrIndexD,
  input  logic [DW-1:0] RsValD,
  input  logic          fetch_ack,
  input  logic          flush,
  output logic          busy,
  output logic          redirect_valid,
  input  logic          redirect_ready,
  output logic [DW-1:0] redirect_pc,
  output logic          adel_valid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] target;
  logic          capture;

  // JR outranks J, which outranks a taken conditional branch.
  always_comb begin
    target = PCPlus4D + SignImmD_shift2;
    if (JumpRegD) begin
      target = RsValD;
    end else if (JumpD) begin
      target = {PCPlus4D[DW-1:28], InstrIndexD, 2'b00};
    end
  end

  assign capture = ValidD & (JumpRegD | JumpD | BranchTakenD) & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_d = WAIT_DS;
            pc_d    = target;
          end
        end
        WAIT_DS: begin
          if (fetch_ack) state_d = REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = pc_q;

`ifdef BR_ADDR_CHECK_EN
  logic adel_q, adel_d;

  always_comb begin
    adel_d = adel_q;
    if (!flush && capture) adel_d = (target[1:0] != 2'b00);
  end

  always_ff @(posedge clock) begin
    if (!reset) adel_q <= 1'b0;
    else        adel_q <= adel_d;
  end

  assign adel_valid = adel_q & redirect_valid;
`else
  assign adel_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
// ============================================================================
// Module   : tb_branch_redirect_unit
// Brief    : Scoreboard bench for branch_redirect_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_redirect_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ValidD, BranchTakenD, JumpD, JumpRegD;
  logic [31:0] PCPlus4D, SignImmD_shift2, RsValD;
  logic [25:0] InstrIndexD;
  logic        fetch_ack, flush, redirect_ready;
  logic        busy, redirect_valid, adel_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

`ifdef BR_ADDR_CHECK_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  branch_redirect_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ValidD         (ValidD),
    .BranchTakenD   (BranchTakenD),
    .JumpD          (JumpD),
    .JumpRegD       (JumpRegD),
    .PCPlus4D       (PCPlus4D),
    .SignImmD_shift2(SignImmD_shift2),
    .InstrIndexD    (InstrIndexD),
    .RsValD         (RsValD),
    .fetch_ack      (fetch_ack),
    .flush          (flush),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .adel_valid     (adel_valid)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clock);
  endtask

  function automatic logic [31:0] model_target(input logic bt, input logic j, input logic jr,
                                               input logic [31:0] pc4, input logic [31:0] imm,
                                               input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] t;
    t = 32'h0;
    if (jr)      t = rs;
    else if (j)  t = {pc4[31:28], idx, 2'b00};
    else if (bt) t = pc4 + imm;
    return t;
  endfunction

  task automatic drive_req(input logic bt, input logic j, input logic jr,
                           input logic [31:0] pc4, input logic [31:0] imm,
                           input logic [25:0] idx, input logic [31:0] rs, input bit push);
    exp_t x;
    ValidD = 1'b1; BranchTakenD = bt; JumpD = j; JumpRegD = jr;
    PCPlus4D = pc4; SignImmD_shift2 = imm; InstrIndexD = idx; RsValD = rs;
    if (push) begin
      x.pc   = model_target(bt, j, jr, pc4, imm, idx, rs);
      x.adel = ADEL_EN && (x.pc[1:0] != 2'b00);
      sb.push_back(x);
    end
  endtask

  task automatic clear_req();
    ValidD = 1'b0; BranchTakenD = 1'b0; JumpD = 1'b0; JumpRegD = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_req();
    PCPlus4D = '0; SignImmD_shift2 = '0; InstrIndexD = '0; RsValD = '0;
    fetch_ack = 1'b0; flush = 1'b0; redirect_ready = 1'b0;
    cyc(); cyc();
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || adel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b valid=%b adel=%b exp 0 0 0", busy, redirect_valid, adel_valid);
    end
    checks++;
    if (redirect_pc !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL reset_pc got %h exp bfc00000", redirect_pc);
    end
    reset = 1'b1;
    cyc();
  endtask

  // Full transaction; the capture-cycle fetch_ack must not count.
  task automatic test_branch();
    drive_req(1'b1, 1'b0, 1'b0, 32'h0040_0004, 32'h0000_0010, 26'h0, 32'h0, 1'b1);
    fetch_ack = 1'b1;
    cyc();
    clear_req(); fetch_ack = 1'b0;
    checks++;
    if (busy !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_wait got busy=%b valid=%b exp 1 0", busy, redirect_valid);
    end
    cyc();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_capture_ack_ignored got valid=%b exp 0", redirect_valid);
    end
    fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_valid got %b exp 1", redirect_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (redirect_pc !== e.pc || adel_valid !== e.adel) begin
        errors++;
        $display("FAIL branch_pc got %h/%b exp %h/%b", redirect_pc, adel_valid, e.pc, e.adel);
      end
    end
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_done got busy=%b valid=%b exp 0 0", busy, redirect_valid);
    end
  endtask

  // Generic capture -> ack -> handshake with target check, used per pattern.
  task automatic test_target(input string name, input logic bt, input logic j, input logic jr,
                             input logic [31:0] pc4, input logic [31:0] imm,
                             input logic [25:0] idx, input logic [31:0] rs);
    drive_req(bt, j, jr, pc4, imm, idx, rs, 1'b1);
    cyc();
    clear_req(); fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid got valid=%b busy=%b exp 1 1", name, redirect_valid, busy);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checks++;
      if (redirect_pc !== e.pc || adel_valid !== e.adel) begin
        errors++;
        $display("FAIL %s_pc got %h/%b exp %h/%b", name, redirect_pc, adel_valid, e.pc, e.adel);
      end
    end
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    drive_req(1'b1, 1'b0, 1'b0, 32'h1000_0000, 32'h0000_0100, 26'h0, 32'h0, 1'b1);
    cyc();
    clear_req(); fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
    e = sb.pop_front();
    held = e.pc;
    for (int i = 0; i < 3; i++) begin
      // A request while busy must be dropped.
      drive_req(1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'h0, 26'h3FF_FFFF, 32'h0, 1'b0);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== held) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b pc=%h exp 1 %h", i, redirect_valid, redirect_pc, held);
      end
      cyc();
    end
    // Request in the handshake cycle is ignored as well.
    redirect_ready = 1'b1;
    cyc();
    redirect_ready = 1'b0;
    clear_req();
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== held) begin
      errors++;
      $display("FAIL bp_release got busy=%b valid=%b pc=%h exp 0 0 %h", busy, redirect_valid, redirect_pc, held);
    end
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_second got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_flush();
    logic [31:0] held;
    drive_req(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 26'h000_0040, 32'h0, 1'b1);
    cyc();
    clear_req(); fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
    e = sb.pop_front();
    held = e.pc;
    flush = 1'b1; redirect_ready = 1'b1;
    cyc();
    flush = 1'b0; redirect_ready = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== held) begin
      errors++;
      $display("FAIL flush_redirect got valid=%b busy=%b pc=%h exp 0 0 %h", redirect_valid, busy, redirect_pc, held);
    end
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 26'h0, 32'h0, 1'b0);
    flush = 1'b1;
    cyc();
    clear_req(); flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || redirect_pc !== held) begin
      errors++;
      $display("FAIL flush_beats_capture got busy=%b pc=%h exp 0 %h", busy, redirect_pc, held);
    end
  endtask

  task automatic test_reset_abort();
    drive_req(1'b1, 1'b0, 1'b0, 32'h0040_0004, 32'h0000_0020, 26'h0, 32'h0, 1'b1);
    cyc();
    clear_req();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait got busy=%b exp 1", busy);
    end
    void'(sb.pop_front());
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'hBFC0_0000) begin
      errors++;
      $display("FAIL abort_reset got busy=%b valid=%b pc=%h exp 0 0 bfc00000", busy, redirect_valid, redirect_pc);
    end
    fetch_ack = 1'b1;
    cyc();
    fetch_ack = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_redirect got valid=%b exp 0", redirect_valid);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_target("jump", 1'b0, 1'b1, 1'b0, 32'hBFC0_0008, 32'h0, 26'h000_0100, 32'h0);
    test_target("wrap", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 26'h0, 32'h0);
    test_target("jr_prio", 1'b1, 1'b0, 1'b1, 32'h0040_0004, 32'h0000_0010, 26'h0, 32'h0040_0002);
    test_target("j_over_b", 1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_0010, 26'h2AA_AAAA, 32'h0);
    test_target("back_neg", 1'b1, 1'b0, 1'b0, 32'h0040_0100, 32'hFFFF_FFF0, 26'h0, 32'h0);
    test_backpressure();
    test_flush();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
